// File: rtl/gray_pkg.sv
// Shared constants and the binary-to-Gray helper for the bin2gray counter.
package gray_pkg;

   localparam int GRAY_W_DEF = 4;
   localparam int GRAY_W_MAX = 16;

   // Reflected binary code: each bit is the XOR of itself and the next higher bit.
   function automatic logic [GRAY_W_MAX-1:0] b2g(input logic [GRAY_W_MAX-1:0] value);
      return value ^ (value >> 1);
   endfunction

endpackage

// File: rtl/b2g_conv.sv
// Combinational binary-to-Gray converter, sized by WIDTH.
module b2g_conv
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEF
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/bin2gray_counter.sv
// Binary counter with a registered Gray-code mirror and terminal-count flag.
// Define GRAY_DOWN_EN to add the dir port and down counting.
module bin2gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] bin_in,
`ifdef GRAY_DOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             count_down;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] gray_d;

`ifdef GRAY_DOWN_EN
   assign count_down = dir;
`else
   assign count_down = 1'b0;
`endif

   always_comb begin
      bin_d = bin_q;
      if (load) begin
         bin_d = bin_in;
      end else if (en) begin
         bin_d = count_down ? (bin_q - ONE) : (bin_q + ONE);
      end
   end

   // Gray is derived from the next binary value so both registers update together.
   b2g_conv #(.WIDTH(WIDTH)) u_b2g_conv (
      .bin  (bin_d),
      .gray (gray_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign bin  = bin_q;
   assign gray = gray_q;
   assign tc   = en & ~load & (count_down ? (bin_q == '0) : (bin_q == ALL_ONES));

endmodule

// File: tb/tb_bin2gray_counter.sv
// Self-checking bench for bin2gray_counter at WIDTH=4 with an arithmetic reference model.
module tb_bin2gray_counter;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         rst;
   logic         en;
   logic         load;
   logic [W-1:0] bin_in;
   logic         dir;
   logic [W-1:0] gray;
   logic [W-1:0] bin;
   logic         tc;

   int total;
   int bad;

   // reference model state
   int  m_bin;
   bit  m_counted;
   bit  checking;
   bit  have_prev;
   logic [W-1:0] prev_gray;

   bin2gray_counter #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .load   (load),
      .bin_in (bin_in),
`ifdef GRAY_DOWN_EN
      .dir    (dir),
`endif
      .gray   (gray),
      .bin    (bin),
      .tc     (tc)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gray_of(input int n);
      return n ^ (n / 2);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: the count as a plain integer modulo 2^W
   always @(posedge clk) begin
      m_counted = 1'b0;
      if (rst) begin
         m_bin = 0;
      end else if (load) begin
         m_bin = int'(bin_in);
      end else if (en) begin
         m_bin = dir ? (m_bin + MOD - 1) % MOD : (m_bin + 1) % MOD;
         m_counted = 1'b1;
      end
   end

   // compare process: every cycle once checking is armed
   always @(negedge clk) begin
      if (checking) begin
         int exp_tc;
         exp_tc = (en && !load && (dir ? (m_bin == 0) : (m_bin == MOD - 1))) ? 1 : 0;
         check("model_bin", int'(bin), m_bin);
         check("model_gray", int'(gray), gray_of(m_bin));
         check("model_tc", int'(tc), exp_tc);
         if (m_counted && have_prev)
            check("one_bit_step", $countones(gray ^ prev_gray), 1);
         prev_gray = gray;
         have_prev = 1'b1;
      end
   end

   // driver: inputs change 2 time units after each rising edge
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load   = 1'b1;
      bin_in = v;
      cycles(1);
      load   = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; m_bin = 0; m_counted = 0;
      checking = 0; have_prev = 0; prev_gray = '0;
      rst = 1'b1; en = 1'b1; load = 1'b1; bin_in = 4'b1010; dir = 1'b0;

      // reset wins over load and enable for 2 cycles
      cycles(1);
      checking = 1'b1;
      cycles(1);
      check("rst_bin", int'(bin), 0);
      check("rst_gray", int'(gray), 0);
      check("rst_tc", int'(tc), 0);
      rst = 1'b0; load = 1'b0; en = 1'b0;
      #1;
      check("rst_tc_idle", int'(tc), 0);

      // full up sweep including wrap
      en = 1'b1;
      cycles(3);
      check("sweep3_gray", int'(gray), 4'b0010);
      cycles(12);
      check("sweep15_bin", int'(bin), 4'b1111);
      check("sweep15_gray", int'(gray), 4'b1000);
      check("sweep15_tc", int'(tc), 1);
      cycles(1);
      check("wrap_bin", int'(bin), 0);
      check("wrap_gray", int'(gray), 0);
      check("wrap_tc", int'(tc), 0);
      cycles(1);
      check("sweep17_gray", int'(gray), 4'b0001);

      // load has priority over enable
      en = 1'b1;
      do_load(4'b1010);
      check("load_bin", int'(bin), 4'b1010);
      check("load_gray", int'(gray), 4'b1111);
      cycles(1);
      check("load_next_bin", int'(bin), 4'b1011);
      check("load_next_gray", int'(gray), 4'b1110);

      // hold
      do_load(4'b0110);
      en = 1'b0;
      cycles(5);
      check("hold_bin", int'(bin), 4'b0110);
      check("hold_gray", int'(gray), 4'b0101);
      check("hold_tc", int'(tc), 0);

      // load while at all-ones suppresses tc
      do_load(4'b1111);
      en = 1'b1; load = 1'b1; bin_in = 4'b0111;
      #1;
      check("tc_masked_by_load", int'(tc), 0);
      cycles(1);
      load = 1'b0;
      check("load7_gray", int'(gray), 4'b0100);
      cycles(1);
      check("step8_gray", int'(gray), 4'b1100);

      // mid-count reset
      do_load(4'b1100);
      rst = 1'b1; en = 1'b1;
      cycles(1);
      check("midrst_bin", int'(bin), 0);
      check("midrst_gray", int'(gray), 0);
      rst = 1'b0;
      cycles(1);
      check("resume_bin", int'(bin), 4'b0001);
      check("resume_gray", int'(gray), 4'b0001);

      // enable toggling
      en = 1'b0; cycles(2);
      en = 1'b1; cycles(3);
      check("toggle_bin", int'(bin), 4'b0100);
      check("toggle_gray", int'(gray), 4'b0110);

`ifdef GRAY_DOWN_EN
      en = 1'b0;
      do_load(4'b0000);
      dir = 1'b1; en = 1'b1;
      #1;
      check("down_tc_at_zero", int'(tc), 1);
      cycles(1);
      check("down_bin", int'(bin), 4'b1111);
      check("down_gray", int'(gray), 4'b1000);
      check("down_tc_after", int'(tc), 0);
      cycles(4);
      check("down5_bin", int'(bin), 4'b1011);
      dir = 1'b0;
      cycles(2);
`endif

      en = 1'b0;
      cycles(2);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin2gray_counter.md
BIN2GRAY_COUNTER -- requirements
Module: bin2gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, sets the counter and code width in bits; legal range is 2..16.
REQ-002 Port: clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  is the reset, which is synchronous and active-high.
REQ-004 Port: en  input  1  is the count enable; when high, the counter advances one step per clock.
REQ-005 Port: load  input  1  is the parallel-load strobe.
REQ-006 Port: bin_in  input  WIDTH  is the binary load value, sampled only when load=1.
REQ-007 Port: dir  input  1  selects direction (0=up, 1=down); this port SHALL exist only when GRAY_DOWN_EN is defined.
REQ-008 Port: gray  output  WIDTH  is the registered Gray-code count.
REQ-009 Port: bin  output  WIDTH  is the registered binary count.
REQ-010 Port: tc  output  1  is the terminal-count flag (combinational).

Function
REQ-011 The block SHALL hold the binary count in a register and SHALL register gray = next_bin XOR (next_bin >> 1) on the same edge, so gray always equals b2g(bin) with zero added latency.
REQ-012 Update priority on each rising clk edge SHALL be rst > load > en > hold.
REQ-013 When load=1, bin SHALL take bin_in and gray SHALL take b2g(bin_in) on the next edge, regardless of en and dir.
REQ-014 When en=1 and counting up, bin SHALL increment modulo 2^WIDTH; all-ones SHALL wrap to 0 (for WIDTH=4, gray goes 1000 -> 0000).
REQ-015 When en=0 and load=0, bin and gray SHALL hold their values.
REQ-016 Between consecutive enabled count steps, gray SHALL change in exactly one bit position, including across wrap-around; load is exempt from this rule.
REQ-017 tc SHALL equal en & ~load & (bin == all-ones) when counting up.
REQ-018 The block SHALL have no other internal state; there is no FSM beyond the count register.

Reset
REQ-019 While rst=1 at a rising edge, bin SHALL become 0 and gray SHALL become 0, regardless of en, load, or dir.
REQ-020 If rst is asserted mid-count or together with load, reset SHALL win; counting SHALL resume from 0 on the first edge after rst falls.
REQ-021 tc SHALL be 0 whenever bin=0 and the counter is counting up, including immediately after reset.

Configuration
REQ-022 Macro GRAY_DOWN_EN, when defined, SHALL add the dir port and down counting.
- With dir=1, bin decrements modulo 2^WIDTH (0 wraps to all-ones).
- With dir=1, tc = en & ~load & (bin == 0).
REQ-023 When GRAY_DOWN_EN is undefined, the dir port SHALL be absent and the counter SHALL be up-only; behaviour SHALL be identical to the macro build with dir tied to 0.

Structure
REQ-024 Shared package gray_pkg SHALL hold the default-width constant GRAY_W_DEF=4 and the pure function b2g(value) = value XOR (value >> 1).
REQ-025 One combinational sub-module, b2g_conv (parameter WIDTH; input bin, output gray), SHALL compute the next-state Gray value. It is instantiated once, on next_bin.
REQ-026 All registers SHALL live in bin2gray_counter, with no latches and no gated clocks.

Verification (WIDTH=4)
REQ-027 Reset: rst=1 for 2 cycles with en=1 and load=1 -> bin=0000, gray=0000, tc=0.
REQ-028 Full up-sweep: en=1 for 17 cycles from 0 -> gray follows 0000,0001,0011,0010,0110,...,1000,0000; exactly one bit changes per step; tc=1 only while bin=1111.
REQ-029 Load: bin_in=1010 with load=1 and en=1 -> next cycle bin=1010, gray=1111; the following cycle (en=1, load=0) gives bin=1011, gray=1110.
REQ-030 Hold: en=0 for 5 cycles at bin=0110 -> bin=0110 and gray=0101 stay stable; tc=0.
REQ-031 Mid-count reset: rst=1 for one cycle at bin=1100 -> next cycle bin=0000, gray=0000; with en=1, the next count is bin=0001, gray=0001.
REQ-032 GRAY_DOWN_EN build: load 0000, then dir=1 and en=1 -> bin=1111, gray=1000; tc=1 during the cycle when bin=0000; the non-macro build is checked to have no dir port.
